display_mux: RTL and testbench
==============================

# display_mux

Time-multiplexed driver for the dual common-anode seven-segment display. Each frame it captures an 8-bit value and drives the shared segment bus with the low nibble on digit 0 and the high nibble on digit 1. Blanking gaps separate the two digits so neither digit shows a ghost of the other. It sits between the switch/adder logic and the board pins, and is the display-side consumer of the two hex nibbles that the sum logic adds.

## Interface
- DWELL, 24000: clock cycles each digit is lit; must be ≥1.
- BLANK, 240: clock cycles both digits are dark between digits; must be ≥1.
- CNT_W, 16: width of the dwell/blank counter; must satisfy 2^CNT_W > max(DWELL, BLANK).
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- s  in  8  value to display; s[3:0] drives digit 0 and s[7:4] drives digit 1.
- seg  out  7  segment drive, active low, bit order {g,f,e,d,c,b,a}.
- an  out  2  anode enables, active low; an[0] is digit 0 and an[1] is digit 1.

## Operation
- FSM states, in a fixed cycle: S_BLANK0 → S_DIG0 → S_BLANK1 → S_DIG1 → S_BLANK0.
- A counter `cnt` (CNT_W bits) runs from 0 to len−1 in each state.
  - len is BLANK in the blank states and DWELL in the digit states.
  - When cnt == len−1, the FSM advances to the next state and cnt returns to 0 on the same edge.
  - Otherwise cnt increments by 1.
- Value capture: `s` is registered into `val` on the last cycle of S_BLANK0, the edge that enters S_DIG0.
  - `val` holds for the whole frame.
  - Changes to `s` at any other time do not affect the current frame (no tearing).
- Outputs in each state:
  - Blank states: an=2'b11, seg=7'h7F.
  - S_DIG0: an=2'b10, seg=dec(val[3:0]).
  - S_DIG1: an=2'b01, seg=dec(val[7:4]).
- Decoder glyphs are 0-9 and A, b, C, d, E, F.
- Invariants:
  - an is never 2'b00.
  - an never moves directly between 2'b10 and 2'b01; a blank state always comes between them.
- Reset values: state=S_BLANK0, cnt=0, val=8'h00, an=2'b11, seg=7'h7F.
- Reset mid-operation: outputs go dark immediately without waiting for a clock edge. After release, operation restarts at the start of S_BLANK0.

## Timing
- an and seg are registered. They change on the same clock edge as the state register, so there is no extra output latency relative to the state.
- After reset release, the first rising edge is cycle 0 of S_BLANK0.
- Frame period is exactly 2·(DWELL+BLANK) cycles.
- Digit 0 is lit from cycle BLANK to BLANK+DWELL−1 of each frame.
- Digit 1 is lit from cycle 2·BLANK+DWELL to the end of the frame.
- Latency from `s` to display: `s` is sampled at frame cycle BLANK−1 and is visible from frame cycle BLANK. A change that misses the sample appears one frame later.
- The counter never wraps past len−1, so there is no overflow path.

## Structure
- Package `display_pkg`:
  - state enum `mux_state_t`.
  - constants SEG_OFF=7'h7F, AN_OFF=2'b11.
  - the 16-entry glyph constant array used for checking.
- Sub-module `seg7_dec`: combinational 4-bit to 7-bit active-low decoder, instantiated once.
  - Its input is selected by the state: val[3:0] in S_DIG0, val[7:4] in S_DIG1.
  - Its output is gated to SEG_OFF in the blank states before the output register.

## Test plan
All scenarios use DWELL=4, BLANK=2, giving a 12-cycle frame.
- Reset and first frame:
  - Hold reset_n=0 → an=2'b11, seg=7'h7F.
  - Release with s=8'h3A. Frame cycles 0-1 are dark.
  - Cycles 2-5: an=2'b10, seg=7'b0001000 (A).
  - Cycles 6-7: dark.
  - Cycles 8-11: an=2'b01, seg=7'b0110000 (3).
- Mid-frame input change:
  - Set s=8'h00 during S_DIG0 of the 8'h3A frame → digit 1 still shows 3 (7'b0110000).
  - Next frame both digits show 7'b1000000 (0).
- Asynchronous reset:
  - Drop reset_n between edges during S_DIG1 → an=2'b11 and seg=7'h7F before the next edge.
  - After release, S_BLANK0 lasts exactly 2 cycles.
- Decoder sweep: s = {n,n} for n = 0..F, one frame each → seg matches the `display_pkg` glyph array on both digits.
- Invariants:
  - Drive random s every cycle for 1000 frames → an is never 2'b00.
  - an never changes directly between 2'b10 and 2'b01.
- Period: over 100 frames, the rising edges of digit 0 enable are exactly 12 cycles apart.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the dual-digit seven-segment multiplexer.
// Holds the FSM state enum, the dark-output constants and the glyph table.
package display_pkg;

  typedef enum logic [1:0] {
    S_BLANK0,
    S_DIG0,
    S_BLANK1,
    S_DIG1
  } mux_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [1:0] AN_OFF  = 2'b11;
  localparam logic [1:0] AN_DIG0 = 2'b10;
  localparam logic [1:0] AN_DIG1 = 2'b01;

  // Active-low {g,f,e,d,c,b,a} glyphs for 0-9, A, b, C, d, E, F.
  localparam logic [6:0] GLYPH [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/display_mux_seg7_dec.sv
// Combinational hex-to-seven-segment decoder, active-low outputs.
// Ports: hex_i nibble in, seg_o {g,f,e,d,c,b,a} out.
module seg7_dec (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    unique case (hex_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/display_mux.sv
// Time-multiplexed driver for a dual common-anode seven-segment display.
// Ports: clk, reset_n (async, low), s value in, seg/an active-low out.
module display_mux #(
  parameter int DWELL = 24000,
  parameter int BLANK = 240,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] s,
  output logic [6:0] seg,
  output logic [1:0] an
);

  import display_pkg::*;

  localparam logic [CNT_W-1:0] DW_M1 = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BL_M1 = CNT_W'(BLANK - 1);

  mux_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_m1;
  logic [7:0]       val_q, val_d;
  logic [1:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       dec_in;
  logic [6:0]       dec_out;
  logic             last;

  assign len_m1 = (state_q == S_DIG0 || state_q == S_DIG1)
                ? DW_M1 : BL_M1;
  assign last   = (cnt_q == len_m1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    val_d   = val_q;
    if (last) begin
      cnt_d = '0;
      unique case (state_q)
        S_BLANK0: begin
          state_d = S_DIG0;
          val_d   = s;
        end
        S_DIG0:   state_d = S_BLANK1;
        S_BLANK1: state_d = S_DIG1;
        default:  state_d = S_BLANK0;
      endcase
    end
  end

  // Outputs are computed from the next state so they register on
  // the same edge as the state itself; the freshly captured value
  // must feed the decoder on the edge entering S_DIG0.
  assign dec_in = (state_d == S_DIG1) ? val_d[7:4] : val_d[3:0];

  seg7_dec u_dec (
    .hex_i (dec_in),
    .seg_o (dec_out)
  );

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    unique case (state_d)
      S_DIG0: begin
        an_d  = AN_DIG0;
        seg_d = dec_out;
      end
      S_DIG1: begin
        an_d  = AN_DIG1;
        seg_d = dec_out;
      end
      default: begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_BLANK0;
      cnt_q   <= '0;
      val_q   <= 8'h00;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_display_mux.sv
// Scoreboard bench for display_mux with DWELL=4, BLANK=2.
// Stimulus pushes expected {an,seg} per cycle; a monitor pops and compares.
module tb_display_mux;

  import display_pkg::*;

  localparam int D = 4;
  localparam int B = 2;
  localparam int F = 2 * (D + B);

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] s = 8'h00;
  logic [6:0] seg;
  logic [1:0] an;

  display_mux #(
    .DWELL (D),
    .BLANK (B),
    .CNT_W (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s       (s),
    .seg     (seg),
    .an      (an)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [8:0] q[$];
  bit         mon_en = 1'b0;
  int         fc = 0;
  logic [7:0] capv = 8'h00;

  localparam logic [8:0] DARK = {AN_OFF, SEG_OFF};

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] exp_at(int c, logic [7:0] v);
    if (c < B)          return DARK;
    else if (c < B + D) return {AN_DIG0, GLYPH[v[3:0]]};
    else if (c < 2*B+D) return DARK;
    else                return {AN_DIG1, GLYPH[v[7:4]]};
  endfunction

  // Drive s for the coming edge and queue what that edge must produce.
  task automatic step(logic [7:0] sv);
    int nfc;
    s   = sv;
    nfc = (fc + 1) % F;
    if (nfc == B) capv = sv;
    q.push_back(exp_at(nfc, capv));
    @(negedge clk);
    fc = nfc;
  endtask

  task automatic release_rst();
    reset_n = 1'b1;
    fc      = 0;
    capv    = 8'h00;
    #1;
    chk("release_dark", {an, seg}, DARK);
    mon_en = 1'b1;
  endtask

  // Scoreboard monitor
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_underflow: got empty queue expected entry");
      end else begin
        chk("sb_out", {an, seg}, q.pop_front());
      end
    end
  end

  // Invariant and period monitor
  logic [1:0] prev_an = 2'b11;
  int cyc = 0;
  int last_rise = -1;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (!reset_n) begin
      prev_an   = AN_OFF;
      last_rise = -1;
    end else begin
      chk("an_not_00", an == 2'b00, 0);
      chk("an_no_direct",
          (prev_an == AN_DIG0 && an == AN_DIG1) ||
          (prev_an == AN_DIG1 && an == AN_DIG0), 0);
      if (an == AN_DIG0 && prev_an != AN_DIG0) begin
        if (last_rise >= 0) chk("dig0_period", cyc - last_rise, F);
        last_rise = cyc;
      end
      prev_an = an;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    s = 8'h3A;
    repeat (3) @(negedge clk);
    chk("reset_state", {an, seg}, DARK);

    // First frame with 3A, s changed to 00 during digit 0.
    release_rst();
    step(8'h3A);
    step(8'h3A);
    chk("f1_dig0_A", {an, seg}, {2'b10, 7'b0001000});
    step(8'h3A);
    while (fc != 8) step(8'h00);
    chk("f1_dig1_3", {an, seg}, {2'b01, 7'b0110000});
    while (fc != 0) step(8'h00);
    while (fc != 2) step(8'h00);
    chk("f2_dig0_0", {an, seg}, {2'b10, 7'b1000000});
    while (fc != 8) step(8'h00);
    chk("f2_dig1_0", {an, seg}, {2'b01, 7'b1000000});
    while (fc != 0) step(8'h00);
    while (fc != 9) step(8'h00);
    chk("pre_rst_dig1", {an, seg}, {2'b01, 7'b1000000});

    // Asynchronous reset between edges.
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("async_dark", {an, seg}, DARK);
    chk("sb_drained", q.size(), 0);
    repeat (2) @(negedge clk);
    chk("reset_hold", {an, seg}, DARK);

    // Decoder sweep, first frame right after release.
    release_rst();
    for (int n = 0; n < 16; n++) begin
      repeat (F) step({n[3:0], n[3:0]});
    end

    // Random s every cycle.
    repeat (1000 * F) step(8'($urandom));

    chk("sb_end_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
